// File: rtl/prewitt_frame_streamer.sv
// Frame-memory pixel source for the Prewitt edge stage: load a frame, then stream it in raster order.
// Optional `define ZERO_BORDER_EN forces the outer ring of pixels to zero on output.
module prewitt_frame_streamer #(
  parameter int ROWS   = 242,
  parameter int COLS   = 247,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(ROWS*COLS),
  parameter int ROW_W  = $clog2(ROWS),
  parameter int COL_W  = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic [ROW_W-1:0]  m_row,
  output logic [COL_W-1:0]  m_col
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(ROWS*COLS);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [ROWS*COLS];
  logic [DATA_W-1:0] ram_q;

  logic [CNT_W-1:0]  rd_addr_q, rd_addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [ROW_W-1:0]  ld_row_q, ld_row_d;
  logic [COL_W-1:0]  ld_col_q, ld_col_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_sof_q, m_sof_d, m_eol_q, m_eol_d, m_eof_q, m_eof_d;
  logic [ROW_W-1:0]  m_row_q, m_row_d;
  logic [COL_W-1:0]  m_col_q, m_col_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic       xfer, last_xfer, wr_ok, rd_issue, out_free, load, border, ld_last_col, ld_last_row;
  logic [1:0] occ;

  always_comb begin
    xfer        = m_valid_q && m_ready;
    last_xfer   = xfer && m_eof_q;
    wr_ok       = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < TOTAL);
    // occ counts pixels in flight or held; output register plus skid hold at most two
    occ         = {1'b0, m_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
    rd_issue    = (state_q != IDLE) && (rd_addr_q < TOTAL) &&
                  ((occ < 2'd2) || ((occ == 2'd2) && xfer));
    out_free    = !m_valid_q || xfer;
    load        = out_free && (skid_valid_q || rd_pend_q);
    ld_last_col = (ld_col_q == COL_W'(COLS-1));
    ld_last_row = (ld_row_q == ROW_W'(ROWS-1));
`ifdef ZERO_BORDER_EN
    border      = (ld_row_q == '0) || ld_last_row || (ld_col_q == '0) || ld_last_col;
`else
    border      = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PRIME;
      PRIME:   state_d = STREAM;
      STREAM:  if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = last_xfer;
  end

  always_comb begin
    rd_addr_d    = rd_addr_q + CNT_W'(rd_issue);
    rd_pend_d    = rd_issue;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    ld_row_d     = ld_row_q;
    ld_col_d     = ld_col_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_sof_d      = m_sof_q;
    m_eol_d      = m_eol_q;
    m_eof_d      = m_eof_q;
    m_row_d      = m_row_q;
    m_col_d      = m_col_q;

    if (out_free) begin
      m_valid_d = load;
      m_sof_d   = 1'b0;
      m_eol_d   = 1'b0;
      m_eof_d   = 1'b0;
      if (load) begin
        m_data_d = border ? '0 : (skid_valid_q ? skid_data_q : ram_q);
        m_sof_d  = (ld_row_q == '0) && (ld_col_q == '0);
        m_eol_d  = ld_last_col;
        m_eof_d  = ld_last_col && ld_last_row;
        m_row_d  = ld_row_q;
        m_col_d  = ld_col_q;
        ld_col_d = ld_last_col ? '0 : ld_col_q + COL_W'(1);
        if (ld_last_col) ld_row_d = ld_last_row ? '0 : ld_row_q + ROW_W'(1);
      end
      // skid drains first so the RAM word arriving this cycle queues behind it
      if (skid_valid_q) begin
        skid_valid_d = rd_pend_q;
        skid_data_d  = ram_q;
      end
    end else if (rd_pend_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ram_q;
    end

    if (last_xfer) begin
      rd_addr_d = '0;
      ld_row_d  = '0;
      ld_col_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (rd_issue) ram_q <= mem[rd_addr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      rd_pend_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ld_row_q     <= '0;
      ld_col_q     <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_sof_q      <= 1'b0;
      m_eol_q      <= 1'b0;
      m_eof_q      <= 1'b0;
      m_row_q      <= '0;
      m_col_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      rd_pend_q    <= rd_pend_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ld_row_q     <= ld_row_d;
      ld_col_q     <= ld_col_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_sof_q      <= m_sof_d;
      m_eol_q      <= m_eol_d;
      m_eof_q      <= m_eof_d;
      m_row_q      <= m_row_d;
      m_col_q      <= m_col_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sof   = m_sof_q;
  assign m_eol   = m_eol_q;
  assign m_eof   = m_eof_q;
  assign m_row   = m_row_q;
  assign m_col   = m_col_q;

endmodule
